// File: rtl/p_acc_stream_pkg.sv
// Shared types, FSM encodings and representable-limit helpers for the
// perceptron streaming accumulator and its adder tree.
package p_acc_stream_pkg;

  typedef enum logic [0:0] {
    INT = 1'b0,
    FXP = 1'b1
  } dtype_t;

  typedef struct packed {
    dtype_t dtype;
    logic   sign;
    int     prec;
    int     frac;
  } dconf_t;

  localparam bit ENABLE  = 1'b1;
  localparam bit DISABLE = 1'b0;

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  // Largest value representable by a configuration, as a raw integer.
  function automatic longint conf_max(input dconf_t c);
    if (c.sign) begin
      return (64'sd1 <<< (c.prec - 1)) - 64'sd1;
    end else begin
      return (64'sd1 <<< c.prec) - 64'sd1;
    end
  endfunction

  function automatic longint conf_min(input dconf_t c);
    if (c.sign) begin
      return -(64'sd1 <<< (c.prec - 1));
    end else begin
      return 64'sd0;
    end
  endfunction

endpackage

// File: rtl/p_add_tree.sv
// One-cycle registered adder tree: extends each lane per its signedness and
// sums all lanes of a beat into an exact SUM_W-bit result.
module p_add_tree
  import p_acc_stream_pkg::*;
#(
  parameter dconf_t I_CONF = '{dtype: INT, sign: 1'b1, prec: 8, frac: 0},
  parameter int     LANES  = 4,
  localparam int    I_PREC = I_CONF.prec,
  localparam int    SUM_W  = I_PREC + $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [LANES*I_PREC-1:0] in_data,
  output logic                    sum_valid,
  output logic [SUM_W-1:0]        sum
);

  logic [SUM_W-1:0] sum_s;

  // Lane reduction; SUM_W covers the worst-case total so no bits are lost.
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < LANES; k++) begin
      if (I_CONF.sign) begin
        sum_s = sum_s + SUM_W'($signed(in_data[k*I_PREC +: I_PREC]));
      end else begin
        sum_s = sum_s + SUM_W'(in_data[k*I_PREC +: I_PREC]);
      end
    end
  end

  // Result register; the sum holds its value between beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_valid <= 1'b0;
      sum       <= '0;
    end else begin
      sum_valid <= in_valid;
      if (in_valid) begin
        sum <= sum_s;
      end
    end
  end

endmodule

// File: rtl/p_acc_stream.sv
// Streaming multi-lane accumulator: sums LANES operands per beat, accumulates a
// burst, then converts the total to O_CONF with sticky udf/ovf/rounded flags.
module p_acc_stream
  import p_acc_stream_pkg::*;
#(
  parameter dconf_t I_CONF    = '{dtype: INT, sign: 1'b1, prec: 8, frac: 0},
  parameter dconf_t O_CONF    = '{dtype: INT, sign: 1'b1, prec: 16, frac: 0},
  parameter int     LANES     = 4,
  parameter int     MAX_BEATS = 256,
  parameter bit     SAT       = ENABLE,
  localparam int    I_PREC    = I_CONF.prec,
  localparam int    O_PREC    = O_CONF.prec,
  localparam int    BEAT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*I_PREC-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [O_PREC-1:0]       out,
  output logic [BEAT_W-1:0]       out_beats,
  output logic                    udf,
  output logic                    ovf,
  output logic                    rounded
);

  localparam int SUM_W = I_PREC + $clog2(LANES);
  localparam int ACC_W = SUM_W + $clog2(MAX_BEATS) + 1;
  localparam int SHIFT = O_CONF.frac - I_CONF.frac;
  localparam int LSH   = (SHIFT > 0) ? SHIFT : 0;
  localparam int RSH   = (SHIFT < 0) ? -SHIFT : 0;
  localparam int CV_W  = ACC_W + LSH;
  localparam int CMP_W = (CV_W > 64) ? CV_W : 64;

  localparam logic signed [CMP_W-1:0] O_MAX_C = CMP_W'(conf_max(O_CONF));
  localparam logic signed [CMP_W-1:0] O_MIN_C = CMP_W'(conf_min(O_CONF));
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0]        RMASK   = ACC_W'((64'd1 << RSH) - 64'd1);

  if (O_CONF.dtype != I_CONF.dtype) begin : g_conf_err
    $error("p_acc_stream: O_CONF.dtype must equal I_CONF.dtype");
  end

  logic [1:0]               state_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic                     acc_ovf_r;
  logic                     acc_udf_r;
  logic [BEAT_W-1:0]        beats_r;
  logic                     beat_acc_s;
  logic                     tree_valid_s;
  logic [SUM_W-1:0]         tree_sum_s;
  logic signed [ACC_W-1:0]  tree_ext_s;
  logic signed [ACC_W:0]    add_wide_s;
  logic signed [ACC_W-1:0]  acc_sum_s;
  logic                     add_ovf_s;
  logic                     add_udf_s;
  logic signed [CMP_W-1:0]  cv_s;
  logic [O_PREC-1:0]        out_s;
  logic                     cv_ovf_s;
  logic                     cv_udf_s;
  logic                     cv_rnd_s;

  assign in_ready   = (state_r == ST_ACC);
  assign beat_acc_s = in_valid & in_ready;

  p_add_tree #(
    .I_CONF (I_CONF),
    .LANES  (LANES)
  ) u_tree (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (beat_acc_s),
    .in_data   (in_data),
    .sum_valid (tree_valid_s),
    .sum       (tree_sum_s)
  );

  // Saturating accumulate; the clamp only engages once a burst runs past MAX_BEATS.
  always_comb begin
    tree_ext_s = '0;
    add_ovf_s  = 1'b0;
    add_udf_s  = 1'b0;
    acc_sum_s  = acc_r;
    if (I_CONF.sign) begin
      tree_ext_s = ACC_W'($signed(tree_sum_s));
    end else begin
      tree_ext_s = ACC_W'($unsigned(tree_sum_s));
    end
    add_wide_s = {acc_r[ACC_W-1], acc_r} + {tree_ext_s[ACC_W-1], tree_ext_s};
    if (!tree_valid_s) begin
      acc_sum_s = acc_r;
    end else if (add_wide_s[ACC_W] != add_wide_s[ACC_W-1]) begin
      if (add_wide_s[ACC_W]) begin
        add_udf_s = 1'b1;
        acc_sum_s = ACC_MIN;
      end else begin
        add_ovf_s = 1'b1;
        acc_sum_s = ACC_MAX;
      end
    end else begin
      acc_sum_s = add_wide_s[ACC_W-1:0];
    end
  end

  // Conversion works on acc_sum_s so the final beat, still in flight during FLUSH, is included.
  always_comb begin
    cv_s     = CMP_W'(acc_sum_s);
    cv_s     = (cv_s <<< LSH) >>> RSH;
    cv_rnd_s = |(acc_sum_s & RMASK);
    cv_ovf_s = acc_ovf_r | add_ovf_s | (cv_s > O_MAX_C);
    cv_udf_s = acc_udf_r | add_udf_s | (cv_s < O_MIN_C);
    if (SAT && (cv_s > O_MAX_C)) begin
      out_s = O_MAX_C[O_PREC-1:0];
    end else if (SAT && (cv_s < O_MIN_C)) begin
      out_s = O_MIN_C[O_PREC-1:0];
    end else begin
      out_s = cv_s[O_PREC-1:0];
    end
  end

  // Burst sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_ACC;
    end else begin
      case (state_r)
        ST_ACC:   if (beat_acc_s && in_last) state_r <= ST_FLUSH;
        ST_FLUSH: state_r <= ST_OUT;
        ST_OUT:   if (out_valid && out_ready) state_r <= ST_ACC;
        default:  state_r <= ST_ACC;
      endcase
    end
  end

  // Accumulator, sticky internal flags and beat counter; cleared once the result is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r     <= '0;
      acc_ovf_r <= 1'b0;
      acc_udf_r <= 1'b0;
      beats_r   <= '0;
    end else if (state_r == ST_FLUSH) begin
      acc_r     <= '0;
      acc_ovf_r <= 1'b0;
      acc_udf_r <= 1'b0;
      beats_r   <= '0;
    end else begin
      if (tree_valid_s) begin
        acc_r     <= acc_sum_s;
        acc_ovf_r <= acc_ovf_r | add_ovf_s;
        acc_udf_r <= acc_udf_r | add_udf_s;
      end
      if (beat_acc_s && (beats_r != BEAT_W'(MAX_BEATS))) begin
        beats_r <= beats_r + BEAT_W'(1);
      end
    end
  end

  // Result registers: loaded leaving FLUSH, held through any backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_beats <= '0;
      udf       <= 1'b0;
      ovf       <= 1'b0;
      rounded   <= 1'b0;
    end else if (state_r == ST_FLUSH) begin
      out_valid <= 1'b1;
      out       <= out_s;
      out_beats <= beats_r;
      udf       <= cv_udf_s;
      ovf       <= cv_ovf_s;
      rounded   <= cv_rnd_s;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p_acc_stream.sv
// Directed bench: three accumulators (INT saturating, INT wrapping, FXP) share
// one stimulus stream and are checked against hand-computed results.
module tb_p_acc_stream;
  import p_acc_stream_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        ready_a, vld_a, udf_a, ovf_a, rnd_a;
  logic [15:0] out_a;
  logic [8:0]  beats_a;
  logic        ready_b, vld_b, udf_b, ovf_b, rnd_b;
  logic [15:0] out_b;
  logic [8:0]  beats_b;
  logic        ready_c, vld_c, udf_c, ovf_c, rnd_c;
  logic [15:0] out_c;
  logic [8:0]  beats_c;

  int n_checks = 0;
  int n_fail   = 0;

  p_acc_stream u_int_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(vld_a), .out_ready(out_ready),
    .out(out_a), .out_beats(beats_a), .udf(udf_a), .ovf(ovf_a), .rounded(rnd_a)
  );

  p_acc_stream #(.SAT(DISABLE)) u_int_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(vld_b), .out_ready(out_ready),
    .out(out_b), .out_beats(beats_b), .udf(udf_b), .ovf(ovf_b), .rounded(rnd_b)
  );

  p_acc_stream #(
    .I_CONF('{dtype: FXP, sign: 1'b1, prec: 8, frac: 4}),
    .O_CONF('{dtype: FXP, sign: 1'b1, prec: 16, frac: 2})
  ) u_fxp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready_c),
    .in_data(in_data), .in_last(in_last), .out_valid(vld_c), .out_ready(out_ready),
    .out(out_c), .out_beats(beats_c), .udf(udf_c), .ovf(ovf_c), .rounded(rnd_c)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_burst(input logic [31:0] data, input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last && (i == n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int k;
    k = 0;
    while (!vld_a && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check_value(tag, longint'(vld_a), 1);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_value(tag, longint'(ready_a), 1);
  endtask

  initial begin
    clk       = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_in_ready", longint'(ready_a), 1);
    check_value("rst_out_valid", longint'(vld_a), 0);
    check_value("rst_out", longint'(out_a), 0);
    check_value("rst_out_beats", longint'(beats_a), 0);
    check_value("rst_flags", longint'({udf_a, ovf_a, rnd_a}), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // single beat {3,2,-1,0}: exact two-cycle latency
    send_burst(32'h00FF0203, 1, 1'b1);
    check_value("t1_valid_t1", longint'(vld_a), 0);
    @(posedge clk); #1;
    check_value("t1_valid_t2", longint'(vld_a), 1);
    check_value("t1_out", longint'($signed(out_a)), 4);
    check_value("t1_beats", longint'(beats_a), 1);
    check_value("t1_flags", longint'({udf_a, ovf_a, rnd_a}), 0);
    check_value("t1_in_ready", longint'(ready_a), 0);
    consume("t1_release");

    // 65 x {127 x4} = 33020 overflows; 64 beats fits
    send_burst(32'h7F7F7F7F, 65, 1'b1);
    wait_result("t2a_wait");
    check_value("t2a_sat_out", longint'($signed(out_a)), 32767);
    check_value("t2a_sat_ovf", longint'(ovf_a), 1);
    check_value("t2a_beats", longint'(beats_a), 65);
    check_value("t2a_wrap_out", longint'($signed(out_b)), -32516);
    check_value("t2a_wrap_ovf", longint'(ovf_b), 1);
    check_value("t2a_fxp_out", longint'($signed(out_c)), 8255);
    check_value("t2a_fxp_flags", longint'({udf_c, ovf_c, rnd_c}), 0);
    consume("t2a_release");
    send_burst(32'h7F7F7F7F, 64, 1'b1);
    wait_result("t2b_wait");
    check_value("t2b_sat_out", longint'($signed(out_a)), 32512);
    check_value("t2b_sat_ovf", longint'(ovf_a), 0);
    check_value("t2b_beats", longint'(beats_a), 64);
    consume("t2b_release");

    // {-128 x4}: 64 beats hits O min exactly, 65 beats underflows
    send_burst(32'h80808080, 64, 1'b1);
    wait_result("t3a_wait");
    check_value("t3a_sat_out", longint'($signed(out_a)), -32768);
    check_value("t3a_sat_udf", longint'(udf_a), 0);
    check_value("t3a_wrap_out", longint'($signed(out_b)), -32768);
    consume("t3a_release");
    send_burst(32'h80808080, 65, 1'b1);
    wait_result("t3b_wait");
    check_value("t3b_sat_out", longint'($signed(out_a)), -32768);
    check_value("t3b_sat_udf", longint'(udf_a), 1);
    check_value("t3b_wrap_out", longint'($signed(out_b)), 32256);
    check_value("t3b_wrap_udf", longint'(udf_b), 1);
    check_value("t3b_fxp_out", longint'($signed(out_c)), -8320);
    consume("t3b_release");

    // backpressure: result held, incoming beats refused
    send_burst(32'h04030201, 1, 1'b1);
    wait_result("t4_wait");
    in_valid = 1'b1;
    in_data  = 32'h7F7F7F7F;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_value("t4_hold_out", longint'($signed(out_a)), 10);
      check_value("t4_hold_valid", longint'(vld_a), 1);
      check_value("t4_hold_ready", longint'(ready_a), 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    consume("t4_release");
    send_burst(32'h01000000, 1, 1'b1);
    wait_result("t4_next_wait");
    check_value("t4_next_out", longint'($signed(out_a)), 1);
    check_value("t4_next_beats", longint'(beats_a), 1);
    consume("t4_next_release");

    // reset mid-burst discards the partial sum
    send_burst(32'h05050505, 2, 1'b0);
    reset = 1'b1;
    #1;
    check_value("t5_rst_valid", longint'(vld_a), 0);
    check_value("t5_rst_ready", longint'(ready_a), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    send_burst(32'h01010101, 1, 1'b1);
    wait_result("t5_wait");
    check_value("t5_out", longint'($signed(out_a)), 4);
    check_value("t5_beats", longint'(beats_a), 1);
    consume("t5_release");

    // FXP frac 4 -> frac 2: 1/16 drops to 0 with rounded set, 4/16 is exactly 1/4
    send_burst(32'h00000001, 1, 1'b1);
    wait_result("t6a_wait");
    check_value("t6a_fxp_out", longint'($signed(out_c)), 0);
    check_value("t6a_fxp_rnd", longint'(rnd_c), 1);
    check_value("t6a_int_out", longint'($signed(out_a)), 1);
    consume("t6a_release");
    send_burst(32'h00000004, 1, 1'b1);
    wait_result("t6b_wait");
    check_value("t6b_fxp_out", longint'($signed(out_c)), 1);
    check_value("t6b_fxp_rnd", longint'(rnd_c), 0);
    consume("t6b_release");

    // beat count saturates at MAX_BEATS
    send_burst(32'h00000000, 300, 1'b1);
    wait_result("t7_wait");
    check_value("t7_beats", longint'(beats_a), 256);
    check_value("t7_out", longint'($signed(out_a)), 0);
    consume("t7_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
